// File: rtl/iob_fifo_dp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// iob_fifo_dp_ctrl_pkg
// Shared definitions for the dual-port-RAM FIFO controllers (synchronous now,
// asynchronous later).
//   fifo_depth(addr_w) : number of RAM words addressed by addr_w bits
//   level_width(addr_w): width needed to hold 0..depth inclusive
//   fifo_acc_t         : per-cycle accepted write/read pair
//   wr_accept/rd_accept: the accept conditions for a request
// -----------------------------------------------------------------------------
package iob_fifo_dp_ctrl_pkg;

    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_acc_t;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int level_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // A write is taken only while there is room.
    function automatic logic wr_accept(input logic w_en, input logic w_full);
        return w_en & ~w_full;
    endfunction

    // A read is taken only while data is stored; there is no fall-through.
    function automatic logic rd_accept(input logic r_en, input logic r_empty);
        return r_en & ~r_empty;
    endfunction

endpackage

// File: rtl/iob_fifo_ptr.sv
// -----------------------------------------------------------------------------
// iob_fifo_ptr
// FIFO pointer register: advances by one when en is high and wraps modulo
// 2**ADDR_W through natural overflow of the ADDR_W-bit register.
//   clk  in  clock, rising edge
//   rst  in  synchronous reset, active-high (pointer -> 0)
//   en   in  advance pointer on this edge
//   ptr  out current pointer value
// -----------------------------------------------------------------------------
module iob_fifo_ptr #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W-1:0] ptr_q;

    // Next pointer value: increment with wrap when enabled.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/iob_fifo_dp_ctrl.sv
// -----------------------------------------------------------------------------
// iob_fifo_dp_ctrl
// Single-clock FIFO controller driving an external dual-port byte-enable RAM.
// Port A of the RAM is write-only (write pointer), port B is read-only (read
// pointer). Tracks the fill level and registered full/empty flags.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   w_en, w_data, w_full     producer side
//   r_en, r_data, r_empty    consumer side; r_data valid one cycle after an
//                            accepted r_en
//   level                    words stored, 0..2**ADDR_W
//   ext_mem_*A               RAM write port (enable, byte enables, addr, data)
//   ext_mem_*B               RAM read port (enable, addr, registered dout)
//
// Optional feature: define IOB_FIFO_ALMOST_FLAGS_EN to add parameter ALMOST_TH
// and the registered outputs almost_full / almost_empty.
// -----------------------------------------------------------------------------
module iob_fifo_dp_ctrl
    import iob_fifo_dp_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    ,
    parameter int ALMOST_TH = 1
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_W-1:0]     w_data,
    output logic                  w_full,
    input  logic                  r_en,
    output logic [DATA_W-1:0]     r_data,
    output logic                  r_empty,
    output logic [ADDR_W:0]       level,
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    output logic                  almost_full,
    output logic                  almost_empty,
`endif
    output logic                  ext_mem_enA,
    output logic [DATA_W/8-1:0]   ext_mem_weA,
    output logic [ADDR_W-1:0]     ext_mem_addrA,
    output logic [DATA_W-1:0]     ext_mem_dinA,
    output logic                  ext_mem_enB,
    output logic [ADDR_W-1:0]     ext_mem_addrB,
    input  logic [DATA_W-1:0]     ext_mem_doutB
);

    localparam int FIFO_DEPTH = fifo_depth(ADDR_W);
    localparam int LEVEL_W    = level_width(ADDR_W);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

    fifo_acc_t          acc;
    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W-1:0]  rptr;

    logic [LEVEL_W-1:0] level_d,   level_q;
    logic               r_empty_d, r_empty_q;
    logic               w_full_d,  w_full_q;
    logic               rvalid_d,  rvalid_q;

    // Accept decisions use the registered flags, so full+read accepts only the
    // read and empty+write accepts only the write.
    always_comb begin
        acc    = '0;
        acc.wr = wr_accept(w_en, w_full_q);
        acc.rd = rd_accept(r_en, r_empty_q);
    end

    iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk (clk),
        .rst (rst),
        .en  (acc.wr),
        .ptr (wptr)
    );

    iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk (clk),
        .rst (rst),
        .en  (acc.rd),
        .ptr (rptr)
    );

    // Level update and the flags derived from the next level, so the flags
    // are registered yet consistent with level on every cycle.
    always_comb begin
        level_d = level_q;
        case ({acc.wr, acc.rd})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
        r_empty_d = (level_d == LEVEL_W'(0));
        w_full_d  = (level_d == LEVEL_FULL);
        rvalid_d  = acc.rd;
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= '0;
            r_empty_q <= 1'b1;
            w_full_q  <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            level_q   <= level_d;
            r_empty_q <= r_empty_d;
            w_full_q  <= w_full_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // RAM port drive: enables only for accepted requests.
    always_comb begin
        ext_mem_enA   = acc.wr;
        ext_mem_weA   = {(DATA_W/8){acc.wr}};
        ext_mem_addrA = wptr;
        ext_mem_dinA  = w_data;
        ext_mem_enB   = acc.rd;
        ext_mem_addrB = rptr;
    end

    // Read data is passed only in the cycle following an accepted read; a
    // reset in between drops the RAM output so stale words never leak.
    always_comb begin
        if (rvalid_q) begin
            r_data = ext_mem_doutB;
        end else begin
            r_data = '0;
        end
    end

    assign level   = level_q;
    assign r_empty = r_empty_q;
    assign w_full  = w_full_q;

`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    localparam logic [LEVEL_W-1:0] AF_TH = LEVEL_W'(FIFO_DEPTH - ALMOST_TH);
    localparam logic [LEVEL_W-1:0] AE_TH = LEVEL_W'(ALMOST_TH);

    logic almost_full_d,  almost_full_q;
    logic almost_empty_d, almost_empty_q;

    // Threshold flags computed from the next level, like full/empty.
    always_comb begin
        almost_full_d  = (level_d >= AF_TH);
        almost_empty_d = (level_d <= AE_TH);
    end

    // Threshold flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_iob_fifo_dp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iob_fifo_dp_ctrl
// Directed bench for iob_fifo_dp_ctrl (DATA_W=32, ADDR_W=4) connected to a
// behavioural dual-port byte-enable RAM with registered port-B read data.
// -----------------------------------------------------------------------------
module tb_iob_fifo_dp_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_en = 1'b0;
    logic [31:0]       w_data = 32'h0;
    logic              w_full;
    logic              r_en = 1'b0;
    logic [31:0]       r_data;
    logic              r_empty;
    logic [4:0]        level;
    logic              ext_mem_enA;
    logic [3:0]        ext_mem_weA;
    logic [3:0]        ext_mem_addrA;
    logic [31:0]       ext_mem_dinA;
    logic              ext_mem_enB;
    logic [3:0]        ext_mem_addrB;
    logic [31:0]       ext_mem_doutB = 32'h0;
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    iob_fifo_dp_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .w_en          (w_en),
        .w_data        (w_data),
        .w_full        (w_full),
        .r_en          (r_en),
        .r_data        (r_data),
        .r_empty       (r_empty),
        .level         (level),
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
`endif
        .ext_mem_enA   (ext_mem_enA),
        .ext_mem_weA   (ext_mem_weA),
        .ext_mem_addrA (ext_mem_addrA),
        .ext_mem_dinA  (ext_mem_dinA),
        .ext_mem_enB   (ext_mem_enB),
        .ext_mem_addrB (ext_mem_addrB),
        .ext_mem_doutB (ext_mem_doutB)
    );

    always #5 clk = ~clk;

    // Behavioural iob_ram_dp_be: byte-enabled write port A, registered read port B.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ext_mem_enA) begin
            for (int b = 0; b < 4; b++) begin
                if (ext_mem_weA[b]) mem[ext_mem_addrA][b*8 +: 8] <= ext_mem_dinA[b*8 +: 8];
            end
        end
        if (ext_mem_enB) ext_mem_doutB <= mem[ext_mem_addrB];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int          m_lvl = 0;
    int          m_wp  = 0;
    int          m_rp  = 0;
    logic [31:0] m_q [$];

    // Observations of the combinational RAM drive taken mid-cycle
    logic        o_ena, o_enb;
    logic [3:0]  o_wea, o_addra, o_addrb;

    task automatic step(input logic rs, input logic we, input logic [31:0] wd, input logic re);
        @(negedge clk);
        rst = rs; w_en = we; w_data = wd; r_en = re;
        #1;
        o_ena = ext_mem_enA; o_enb = ext_mem_enB; o_wea = ext_mem_weA;
        o_addra = ext_mem_addrA; o_addrb = ext_mem_addrB;
        @(posedge clk);
        #1;
    endtask

    // One FIFO cycle with the expected behaviour derived from the model.
    task automatic do_op(input logic we, input logic [31:0] wd, input logic re);
        logic        wacc, racc;
        logic [31:0] exp_d;
        wacc = we && (m_lvl < DEPTH);
        racc = re && (m_lvl > 0);
        step(1'b0, we, wd, re);
        check_val("enA", 32'(o_ena), 32'(wacc));
        check_val("enB", 32'(o_enb), 32'(racc));
        check_val("weA", 32'(o_wea), wacc ? 32'hF : 32'h0);
        if (wacc) begin
            check_val("addrA", 32'(o_addra), 32'(m_wp));
            m_q.push_back(wd);
            m_wp = (m_wp + 1) % DEPTH;
        end
        if (racc) begin
            check_val("addrB", 32'(o_addrb), 32'(m_rp));
            exp_d = m_q.pop_front();
            check_val("r_data", r_data, exp_d);
            m_rp = (m_rp + 1) % DEPTH;
        end
        if (wacc && !racc) m_lvl++;
        if (racc && !wacc) m_lvl--;
        check_val("level", 32'(level), 32'(m_lvl));
        check_val("r_empty", 32'(r_empty), 32'(m_lvl == 0));
        check_val("w_full", 32'(w_full), 32'(m_lvl == DEPTH));
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
        check_val("almost_full", 32'(almost_full), 32'(m_lvl >= DEPTH - 1));
        check_val("almost_empty", 32'(almost_empty), 32'(m_lvl <= 1));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_level"}, 32'(level), 32'h0);
        check_val({tag, "_r_empty"}, 32'(r_empty), 32'h1);
        check_val({tag, "_w_full"}, 32'(w_full), 32'h0);
        check_val({tag, "_r_data"}, r_data, 32'h0);
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
        check_val({tag, "_almost_full"}, 32'(almost_full), 32'h0);
        check_val({tag, "_almost_empty"}, 32'(almost_empty), 32'h1);
`endif
    endtask

    initial begin
        // Reset
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check_reset_state("rst");
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("rst_enA", 32'(o_ena), 32'h0);
        check_val("rst_enB", 32'(o_enb), 32'h0);

        // 1. fill 0x20..0x2F, then a rejected 17th write
        for (int i = 0; i < 16; i++) do_op(1'b1, 32'h20 + 32'(i), 1'b0);
        do_op(1'b1, 32'hDEAD_BEEF, 1'b0);

        // 2. drain in order
        for (int i = 0; i < 16; i++) do_op(1'b0, 32'h0, 1'b1);

        // 3. read while empty, then write+read when empty accepts only the write
        do_op(1'b0, 32'h0, 1'b1);
        do_op(1'b1, 32'h30, 1'b1);
        do_op(1'b0, 32'h0, 1'b1);

        // 4. interleaved 20 writes / 20 reads across the pointer wrap
        for (int i = 0; i < 20; i++) do_op(1'b1, 32'h40 + 32'(i), (i > 0));
        do_op(1'b0, 32'h0, 1'b1);

        // 5. level 8, ten simultaneous pairs, then full with a pair
        for (int i = 0; i < 8; i++) do_op(1'b1, 32'h60 + 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) do_op(1'b1, 32'h70 + 32'(i), 1'b1);
        for (int i = 0; i < 8; i++) do_op(1'b1, 32'h80 + 32'(i), 1'b0);
        do_op(1'b1, 32'hAA, 1'b1);

        // 6. drain to level 5, then reset with a read in flight
        for (int i = 0; i < 10; i++) do_op(1'b0, 32'h0, 1'b1);
        check_val("pre_rst_level", 32'(level), 32'h5);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        m_lvl = 0; m_wp = 0; m_rp = 0; m_q.delete();
        check_reset_state("midrst");
        do_op(1'b1, 32'h99, 1'b0);
        do_op(1'b0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
